// File: rtl/fifo_ser.sv
// fifo_ser: pops words from the upstream FIFO read port and streams them
// out MSB-first on a 1-bit valid/ready link, counting delivered words and failed reads.
module fifo_ser #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned TMO    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              empty,
    input  logic              rd_ack,
    input  logic              rd_err,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              rd_en,
    input  logic              ser_ready,
    output logic              ser_data,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [3:0]        err_cnt
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned TMO_W = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        SHIFT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  shreg;
    logic [IDX_W-1:0]   bit_idx;
    logic [TMO_W-1:0]   tmo_cnt;

    logic               xfer;
    logic               xfer_last;
    logic               load;
    logic               fail;

    // Ack has priority over err; a read fails on err or on the last timeout cycle.
    always_comb begin
        xfer      = (state == SHIFT) && ser_ready;
        xfer_last = xfer && (bit_idx == LAST_IDX);
        load      = (state == WAIT) && rd_ack;
        fail      = (state == WAIT) && !rd_ack && (rd_err || (tmo_cnt == TMO_LAST));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = REQ;
            REQ:     state_nxt = WAIT;
            WAIT: begin
                if (load)      state_nxt = SHIFT;
                else if (fail) state_nxt = IDLE;
            end
            SHIFT:   if (xfer_last) state_nxt = empty ? IDLE : REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (load) begin
            shreg   <= fifo_data;
            bit_idx <= '0;
        end else if (xfer) begin
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            bit_idx <= bit_idx + 1'b1;
        end
    end

    // REQ always precedes WAIT, so clearing here gives a fresh count on every WAIT entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == REQ) begin
            tmo_cnt <= '0;
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
        end else if (xfer_last) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (fail && (err_cnt != 4'hF)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    always_comb begin
        rd_en     = (state == REQ);
        ser_valid = (state == SHIFT);
        ser_data  = (state == SHIFT) && shreg[DATA_W-1];
        ser_last  = (state == SHIFT) && (bit_idx == LAST_IDX);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_fifo_ser.sv
// Directed bench for fifo_ser with a behavioural FIFO read-port responder.
module tb_fifo_ser;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        empty;
    logic        rd_ack = 1'b0;
    logic        rd_err = 1'b0;
    logic [31:0] fifo_data = '0;
    logic        rd_en;
    logic        ser_ready = 1'b0;
    logic        ser_data;
    logic        ser_valid;
    logic        ser_last;
    logic        busy;
    logic [7:0]  word_cnt;
    logic [3:0]  err_cnt;

    int checks = 0;
    int failures = 0;

    // FIFO model: 0 normal, 1 always err, 2 silent, 3 ack+err together
    int          mode = 0;
    logic        use_fake = 1'b0;
    logic        fake_empty = 1'b1;
    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    always #5 clk = ~clk;

    assign empty = use_fake ? fake_empty : (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        rd_ack <= 1'b0;
        rd_err <= 1'b0;
        if (rd_en) begin
            if (mode == 1) begin
                rd_err <= 1'b1;
            end else if (mode == 0 || mode == 3) begin
                if (wr_cnt != rd_cnt) begin
                    rd_ack    <= 1'b1;
                    rd_err    <= (mode == 3);
                    fifo_data <= mem[rd_cnt % 1024];
                    rd_cnt    <= rd_cnt + 1;
                end else begin
                    rd_err <= 1'b1;
                end
            end
        end
    end

    fifo_ser #(.DATA_W(32), .CNT_W(8), .TMO(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .empty     (empty),
        .rd_ack    (rd_ack),
        .rd_err    (rd_err),
        .fifo_data (fifo_data),
        .rd_en     (rd_en),
        .ser_ready (ser_ready),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy),
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt)
    );

    task automatic push(input logic [31:0] d);
        mem[wr_cnt % 1024] = d;
        wr_cnt = wr_cnt + 1;
    endtask

    // Gathers one word; ready follows pat[0..3] cyclically. Called at a negedge.
    task automatic collect(input logic [3:0] pat, input int budget,
                           output logic [31:0] w, output int nbits,
                           output int last_bad, output int hold_bad);
        logic pv, pd, pl;
        w = '0; nbits = 0; last_bad = 0; hold_bad = 0;
        pv = 1'b0; pd = 1'b0; pl = 1'b0;
        for (int i = 0; i < budget && nbits < 32; i++) begin
            if (pv && !(ser_valid === 1'b1 && ser_data === pd && ser_last === pl))
                hold_bad++;
            ser_ready = pat[2'(i % 4)];
            pv = 1'b0;
            if (ser_valid) begin
                if (ser_ready) begin
                    if (ser_last !== (nbits == 31)) last_bad++;
                    w = {w[30:0], ser_data};
                    nbits++;
                end else begin
                    pv = 1'b1; pd = ser_data; pl = ser_last;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, ser_valid, ser_data, ser_last, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00000", {rd_en, ser_valid, ser_data, ser_last, busy});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, word_cnt, err_cnt} !== 13'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b word_cnt=%0d err_cnt=%0d expected 0/0/0", busy, word_cnt, err_cnt);
        end
    endtask

    task automatic test_single;
        logic [31:0] w;
        int nb, lb, hb;
        ser_ready = 1'b1;
        push(32'hA500_0001);
        @(negedge clk);
        checks++;
        if (rd_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_rd_en_cycle1: rd_en=%b busy=%b expected 1/1", rd_en, busy);
        end
        @(negedge clk);
        checks++;
        if (rd_en !== 1'b0 || ser_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_wait_cycle2: rd_en=%b ser_valid=%b expected 0/0", rd_en, ser_valid);
        end
        @(negedge clk);
        checks++;
        if (ser_valid !== 1'b1 || ser_data !== 1'b1) begin
            failures++;
            $display("FAIL single_first_bit_cycle3: ser_valid=%b ser_data=%b expected 1/1", ser_valid, ser_data);
        end
        collect(4'b1111, 100, w, nb, lb, hb);
        checks++;
        if (w !== 32'hA500_0001 || nb != 32) begin
            failures++;
            $display("FAIL single_word: got %h (%0d bits) expected a5000001 (32 bits)", w, nb);
        end
        checks++;
        if (lb != 0) begin
            failures++;
            $display("FAIL single_last: bad ser_last on %0d bits expected 0", lb);
        end
        checks++;
        if (word_cnt !== 8'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_cnt: word_cnt=%0d busy=%b expected 1/0", word_cnt, busy);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] w;
        int nb, lb, hb;
        push(32'hFFFF_0000);
        collect(4'b1001, 300, w, nb, lb, hb);
        checks++;
        if (w !== 32'hFFFF_0000 || nb != 32) begin
            failures++;
            $display("FAIL bp_word: got %h (%0d bits) expected ffff0000 (32 bits)", w, nb);
        end
        checks++;
        if (hb != 0 || lb != 0) begin
            failures++;
            $display("FAIL bp_hold: hold errors %0d last errors %0d expected 0/0", hb, lb);
        end
        @(negedge clk);
        checks++;
        if (word_cnt !== 8'd2) begin
            failures++;
            $display("FAIL bp_cnt: word_cnt=%0d expected 2", word_cnt);
        end
    endtask

    task automatic test_ack_and_err;
        logic [31:0] w;
        int nb, lb, hb;
        mode = 3;
        push(32'h1234_5678);
        collect(4'b1111, 100, w, nb, lb, hb);
        mode = 0;
        @(negedge clk);
        checks++;
        if (w !== 32'h1234_5678 || err_cnt !== 4'd0 || word_cnt !== 8'd3) begin
            failures++;
            $display("FAIL ack_wins: word=%h err_cnt=%0d word_cnt=%0d expected 12345678/0/3", w, err_cnt, word_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_w [0:7];
        logic [31:0] w;
        int nwords, nbits, pulses, gap, gap_bad, data_bad;
        for (int k = 0; k < 8; k++) begin
            exp_w[k] = 32'h8000_0001 ^ (32'h0101_0101 * k);
            push(exp_w[k]);
        end
        ser_ready = 1'b1;
        w = '0; nwords = 0; nbits = 0; pulses = 0; gap = 0; gap_bad = 0; data_bad = 0;
        for (int i = 0; i < 600 && nwords < 8; i++) begin
            if (rd_en) pulses++;
            if (ser_valid) begin
                if (nbits == 0 && nwords > 0 && gap != 2) gap_bad++;
                gap = 0;
                w = {w[30:0], ser_data};
                nbits++;
                if (nbits == 32) begin
                    if (w !== exp_w[nwords]) data_bad++;
                    nwords++;
                    nbits = 0;
                end
            end else if (nwords > 0 || nbits > 0) begin
                gap++;
            end
            @(negedge clk);
        end
        checks++;
        if (nwords != 8 || data_bad != 0) begin
            failures++;
            $display("FAIL b2b_words: got %0d words %0d bad expected 8 words 0 bad", nwords, data_bad);
        end
        checks++;
        if (pulses != 8) begin
            failures++;
            $display("FAIL b2b_rd_en: got %0d pulses expected 8", pulses);
        end
        checks++;
        if (gap_bad != 0) begin
            failures++;
            $display("FAIL b2b_gap: %0d gaps not equal to 2 expected 0", gap_bad);
        end
        checks++;
        if (word_cnt !== 8'd11 || busy !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end: word_cnt=%0d busy=%b empty=%b expected 11/0/1", word_cnt, busy, empty);
        end
    endtask

    task automatic test_error_timeout;
        use_fake = 1'b1;
        mode = 1;
        fake_empty = 1'b0;
        @(negedge clk);
        fake_empty = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (err_cnt !== 4'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_err: err_cnt=%0d busy=%b expected 1/0", err_cnt, busy);
        end
        mode = 2;
        fake_empty = 1'b0;
        @(negedge clk);
        fake_empty = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (err_cnt !== 4'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tmo_early: err_cnt=%0d busy=%b after 4 WAIT cycles expected 1/1", err_cnt, busy);
        end
        @(negedge clk);
        checks++;
        if (err_cnt !== 4'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL tmo: err_cnt=%0d busy=%b expected 2/0", err_cnt, busy);
        end
        mode = 1;
        fake_empty = 1'b0;
        repeat (70) @(negedge clk);
        fake_empty = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (err_cnt !== 4'd15 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_sat: err_cnt=%0d busy=%b expected 15/0", err_cnt, busy);
        end
        mode = 0;
        use_fake = 1'b0;
    endtask

    task automatic test_reset_mid_shift;
        int n;
        ser_ready = 1'b1;
        push(32'hFFFF_FFFF);
        n = 0;
        while (n < 50 && ser_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (ser_valid !== 1'b1 || ser_data !== 1'b1) begin
            failures++;
            $display("FAIL mid_shift_pre: ser_valid=%b ser_data=%b expected 1/1", ser_valid, ser_data);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, ser_valid, ser_data, ser_last, busy} !== 5'b0 || word_cnt !== 8'd0 || err_cnt !== 4'd0) begin
            failures++;
            $display("FAIL mid_shift_async: outs=%b word_cnt=%0d err_cnt=%0d expected 00000/0/0",
                     {rd_en, ser_valid, ser_data, ser_last, busy}, word_cnt, err_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ser_valid !== 1'b0 || word_cnt !== 8'd0 || err_cnt !== 4'd0) begin
            failures++;
            $display("FAIL mid_shift_after: busy=%b ser_valid=%b word_cnt=%0d err_cnt=%0d expected 0/0/0/0",
                     busy, ser_valid, word_cnt, err_cnt);
        end
    endtask

    task automatic test_wrap;
        int bits;
        logic saw255, done;
        for (int k = 0; k < 256; k++) push(32'(k * 32'h0101_0101));
        ser_ready = 1'b1;
        bits = 0; saw255 = 1'b0; done = 1'b0;
        for (int i = 0; i < 256 * 34 + 200 && !done; i++) begin
            if (ser_valid) bits++;
            if (word_cnt === 8'd255) saw255 = 1'b1;
            @(negedge clk);
            done = (wr_cnt == rd_cnt) && (busy === 1'b0);
        end
        checks++;
        if (!done || bits != 8192) begin
            failures++;
            $display("FAIL wrap_stream: done=%b bits=%0d expected 1/8192", done, bits);
        end
        checks++;
        if (word_cnt !== 8'd0 || !saw255) begin
            failures++;
            $display("FAIL wrap_cnt: word_cnt=%0d saw255=%b expected 0/1", word_cnt, saw255);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_ack_and_err;
        test_back_to_back;
        test_error_timeout;
        test_reset_mid_shift;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
